// File: rtl/pipe_pkg.sv
// Shared pipeline types: PCSrc encodings, NOP word, fetch FSM states and IF/ID payload.
package pipe_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PCSRC_W = 3;

  // Encodings also used by the decode controller when it drives PCSrc
  typedef enum logic [PCSRC_W-1:0] {
    PC_SEQ = 3'd0,
    PC_BR  = 3'd1,
    PC_J   = 3'd2,
    PC_JAL = 3'd3,
    PC_JR  = 3'd4
  } pcsrc_e;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
  import pipe_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ready;

  modport master (output imem_addr, imem_req, input imem_rdata, imem_ready);
  modport slave  (input imem_addr, imem_req, output imem_rdata, imem_ready);

endinterface

// File: rtl/next_pc_gen.sv
// Combinational redirect target and redirect qualifier from decode's PCSrc and IF/ID contents.
module next_pc_gen
  import pipe_pkg::*;
(
  input  logic [PCSRC_W-1:0] pcsrc_i,
  input  logic               stall_i,
  input  logic [25:0]        inst_i,
  input  logic [XLEN-1:0]    pc4_i,
  input  logic [XLEN-1:0]    jr_target_i,
  output logic [XLEN-1:0]    target_c_o,
  output logic               redirect_c_o
);

  logic take_c;

  always_comb begin
    target_c_o = pc4_i;
    take_c     = 1'b0;
    case (pcsrc_i)
      PC_BR: begin
        target_c_o = pc4_i + {{14{inst_i[15]}}, inst_i[15:0], 2'b00};
        take_c     = 1'b1;
      end
      PC_J, PC_JAL: begin
        target_c_o = {pc4_i[31:28], inst_i, 2'b00};
        take_c     = 1'b1;
      end
      PC_JR: begin
        target_c_o = jr_target_i;
        take_c     = 1'b1;
      end
      default: ;
    endcase
    // Stall wins: decode re-presents the redirect once the stall clears
    redirect_c_o = take_c & ~stall_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, imem wait states, redirects and load-use stall.
// Define DELAY_SLOT_EN to keep the word after a control transfer (MIPS delay slot).
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [XLEN-1:0] NOP_INST = NOP_WORD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [PCSRC_W-1:0]  PCSrc,
  input  logic [XLEN-1:0]     jr_target,
  fetch_stage_if.master       imem,
  output logic [XLEN-1:0]     IF_ID_Inst,
  output logic [XLEN-1:0]     IF_ID_PC4,
  output logic                IF_ID_valid
);

`ifdef DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  localparam if_id_t BUBBLE = '{inst: NOP_INST, pc4: '0, valid: 1'b0};

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tgt_q;
  logic            req_q;
  logic            squash_q;
  logic            redir_pending_q;
  if_id_t          if_id_q;

  logic [XLEN-1:0] target_c;
  logic            redirect_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic            keep_c;

  next_pc_gen u_next_pc_gen (
    .pcsrc_i      (PCSrc),
    .stall_i      (stall),
    .inst_i       (if_id_q.inst[25:0]),
    .pc4_i        (if_id_q.pc4),
    .jr_target_i  (jr_target),
    .target_c_o   (target_c),
    .redirect_c_o (redirect_c)
  );

  assign pc_plus4_c = pc_q + XLEN'(4);

  // Returned word enters IF/ID: not stalled, not wrong-path, and not flushed by a redirect
  assign keep_c = imem.imem_ready & ~stall & ~squash_q & (DelaySlot | ~redirect_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      tgt_q           <= '0;
      req_q           <= 1'b0;
      squash_q        <= 1'b0;
      redir_pending_q <= 1'b0;
      if_id_q         <= BUBBLE;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH, WAIT: begin
          if (imem.imem_ready) begin
            state_q  <= FETCH;
            squash_q <= 1'b0;
            if (keep_c) begin
              if_id_q         <= '{inst: imem.imem_rdata, pc4: pc_plus4_c, valid: 1'b1};
              redir_pending_q <= 1'b0;
            end else if (!stall) begin
              if_id_q <= BUBBLE;
            end
            // A wrong-path response retires even under stall; a delay-slot target waits for its word
            if (redirect_c) begin
              pc_q <= target_c;
            end else if (squash_q || (redir_pending_q && !stall)) begin
              pc_q <= tgt_q;
            end else if (!stall) begin
              pc_q <= pc_plus4_c;
            end
          end else begin
            state_q <= WAIT;
            if (!stall) begin
              if_id_q <= BUBBLE;
            end
            // Address must stay put while the request is outstanding; remember where to go next
            if (redirect_c) begin
              tgt_q <= target_c;
              if (DelaySlot) begin
                redir_pending_q <= 1'b1;
              end else begin
                squash_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = req_q;
  assign IF_ID_Inst     = if_id_q.inst;
  assign IF_ID_PC4      = if_id_q.pc4;
  assign IF_ID_valid    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_stage;
  import pipe_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [2:0]  PCSrc;
  logic [31:0] jr_target;
  logic [31:0] IF_ID_Inst;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_valid;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .jr_target   (jr_target),
    .imem        (imem_bus),
    .IF_ID_Inst  (IF_ID_Inst),
    .IF_ID_PC4   (IF_ID_PC4),
    .IF_ID_valid (IF_ID_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the architectural fetch state
  bit          m_boot, m_req, m_drop, m_dslot, m_valid;
  logic [31:0] m_pc, m_tgt, m_inst, m_pc4;
  logic [31:0] ovr_addr, ovr_word;

  logic [97:0] obs;
  assign obs = {imem_bus.imem_addr, imem_bus.imem_req, IF_ID_Inst, IF_ID_PC4, IF_ID_valid};

  localparam logic [97:0] RESET_VEC = {RST_PC, 1'b0, 32'h0, 32'h0, 1'b0};

  function automatic logic [97:0] model_vec();
    return {m_pc, m_req, m_inst, m_pc4, m_valid};
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == ovr_addr) return ovr_word;
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_req = 1'b0; m_drop = 1'b0; m_dslot = 1'b0;
    m_pc = RST_PC; m_tgt = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_edge(input bit st, input logic [2:0] src, input logic [31:0] jr,
                            input bit rdy, input logic [31:0] word);
    logic [31:0] tgt, sext, nxt;
    bit redir, keep;
    if (m_boot) begin
      m_boot = 1'b0;
      m_req  = 1'b1;
    end else begin
      redir = (src >= 3'd1) && (src <= 3'd4) && !st;
      sext  = {{16{m_inst[15]}}, m_inst[15:0]};
      case (src)
        3'd1:       tgt = m_pc4 + sext * 32'd4;
        3'd2, 3'd3: tgt = (m_pc4 & 32'hF000_0000) | ((m_inst & 32'h03FF_FFFF) << 2);
        3'd4:       tgt = jr;
        default:    tgt = m_pc4;
      endcase
      if (rdy) begin
        keep = !st && !m_drop && (DS || !redir);
        if (redir)        nxt = tgt;
        else if (m_drop)  nxt = m_tgt;
        else if (st)      nxt = m_pc;
        else if (m_dslot) nxt = m_tgt;
        else              nxt = m_pc + 32'd4;
        if (keep) begin
          m_inst = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
          m_dslot = 1'b0;
        end else if (!st) begin
          m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end
        m_drop = 1'b0;
        m_pc   = nxt;
      end else begin
        if (!st) begin
          m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end
        if (redir) begin
          m_tgt = tgt;
          if (DS) m_dslot = 1'b1;
          else    m_drop  = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs at negedge, advance model, return #1 after the posedge
  task automatic cyc(input bit st, input logic [2:0] src, input logic [31:0] jr, input bit rdy);
    logic [31:0] w;
    @(negedge clk);
    w = rdy ? word_at(m_pc) : 32'hDEAD_BEEF;
    stall = st; PCSrc = src; jr_target = jr;
    imem_bus.imem_ready = rdy; imem_bus.imem_rdata = w;
    model_edge(st, src, jr, rdy, w);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; stall = 1'b0; PCSrc = 3'd0; jr_target = 32'h0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; PCSrc = 3'd0; jr_target = 32'h0;
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'h0;
    ovr_addr = 32'hFFFF_FFFF; ovr_word = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", obs, RESET_VEC);
    end
    rst_n = 1'b1;
    cyc(0, 3'd0, 32'h0, 1'b1);
    checks++;
    if (imem_bus.imem_addr !== RST_PC || imem_bus.imem_req !== 1'b1 || IF_ID_valid !== 1'b0) begin
      errors++; $display("FAIL boot_first_fetch got addr=%h req=%b valid=%b exp addr=%h req=1 valid=0",
                         imem_bus.imem_addr, imem_bus.imem_req, IF_ID_valid, RST_PC);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 3'd0, 32'h0, 1'b1);
      checks++;
      if (IF_ID_PC4 !== RST_PC + 32'(4 * i) || IF_ID_valid !== 1'b1) begin
        errors++; $display("FAIL seq_pc4_%0d got=%h/%b exp=%h/1", i, IF_ID_PC4, IF_ID_valid, RST_PC + 32'(4 * i));
      end
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL seq_model_%0d got=%h exp=%h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    ovr_addr = 32'h0000_3004; ovr_word = 32'h1000_FFFE;
    repeat (3) cyc(0, 3'd0, 32'h0, 1'b1);
    checks++;
    if (IF_ID_Inst !== 32'h1000_FFFE || IF_ID_PC4 !== 32'h0000_3008) begin
      errors++; $display("FAIL beq_in_ifid got=%h/%h exp=1000fffe/00003008", IF_ID_Inst, IF_ID_PC4);
    end
    cyc(0, 3'd1, 32'h0, 1'b1);
    checks++;
    if (imem_bus.imem_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL beq_target got=%h exp=00003000", imem_bus.imem_addr);
    end
    checks++;
    if (DS) begin
      if (IF_ID_valid !== 1'b1 || IF_ID_PC4 !== 32'h0000_300C) begin
        errors++; $display("FAIL beq_delay_slot got=%b/%h exp=1/0000300c", IF_ID_valid, IF_ID_PC4);
      end
    end else if (IF_ID_valid !== 1'b0 || IF_ID_Inst !== 32'h0) begin
      errors++; $display("FAIL beq_bubble got=%b/%h exp=0/00000000", IF_ID_valid, IF_ID_Inst);
    end
  endtask

  task automatic test_stall_jr();
    cyc(0, 3'd0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 3'd4, 32'h0000_3100, 1'b1);
      checks++;
      if (imem_bus.imem_addr !== 32'h0000_3004 || IF_ID_PC4 !== 32'h0000_3004 || IF_ID_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d got=%h/%h/%b exp=00003004/00003004/1",
                           i, imem_bus.imem_addr, IF_ID_PC4, IF_ID_valid);
      end
    end
    cyc(0, 3'd4, 32'h0000_3100, 1'b1);
    checks++;
    if (imem_bus.imem_addr !== 32'h0000_3100) begin
      errors++; $display("FAIL jr_after_stall got=%h exp=00003100", imem_bus.imem_addr);
    end
    checks++;
    if (obs !== model_vec()) begin
      errors++; $display("FAIL jr_model got=%h exp=%h", obs, model_vec());
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    ovr_addr = 32'h0000_3010; ovr_word = 32'h0800_0C80;
    repeat (5) cyc(0, 3'd0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 3'd0, 32'h0, 1'b0);
      checks++;
      if (imem_bus.imem_addr !== 32'h0000_3010 || IF_ID_valid !== 1'b0 || imem_bus.imem_req !== 1'b1) begin
        errors++; $display("FAIL wait_hold_%0d got=%h/%b/%b exp=00003010/0/1",
                           i, imem_bus.imem_addr, IF_ID_valid, imem_bus.imem_req);
      end
    end
    cyc(0, 3'd0, 32'h0, 1'b1);
    checks++;
    if (IF_ID_PC4 !== 32'h0000_3014 || IF_ID_valid !== 1'b1 || IF_ID_Inst !== 32'h0800_0C80) begin
      errors++; $display("FAIL wait_capture got=%h/%b/%h exp=00003014/1/08000c80", IF_ID_PC4, IF_ID_valid, IF_ID_Inst);
    end
  endtask

  task automatic test_redirect_wait();
    cyc(1, 3'd0, 32'h0, 1'b0);
    checks++;
    if (IF_ID_valid !== 1'b1 || imem_bus.imem_addr !== 32'h0000_3014) begin
      errors++; $display("FAIL wait_stall_hold got=%b/%h exp=1/00003014", IF_ID_valid, imem_bus.imem_addr);
    end
    cyc(0, 3'd2, 32'h0, 1'b0);
    checks++;
    if (imem_bus.imem_addr !== 32'h0000_3014 || IF_ID_valid !== 1'b0) begin
      errors++; $display("FAIL j_in_wait_hold got=%h/%b exp=00003014/0", imem_bus.imem_addr, IF_ID_valid);
    end
    cyc(0, 3'd0, 32'h0, 1'b0);
    cyc(0, 3'd0, 32'h0, 1'b1);
    checks++;
    if (imem_bus.imem_addr !== 32'h0000_3200) begin
      errors++; $display("FAIL j_resume got=%h exp=00003200", imem_bus.imem_addr);
    end
    checks++;
    if (IF_ID_valid !== DS) begin
      errors++; $display("FAIL j_response_fate got=%b exp=%b", IF_ID_valid, DS);
    end
    checks++;
    if (obs !== model_vec()) begin
      errors++; $display("FAIL j_model got=%h exp=%h", obs, model_vec());
    end
  endtask

  task automatic test_reset_midwait();
    cyc(0, 3'd0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", obs, RESET_VEC);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 3'd0, 32'h0, 1'b1);
    checks++;
    if (imem_bus.imem_addr !== RST_PC || imem_bus.imem_req !== 1'b1 || IF_ID_valid !== 1'b0) begin
      errors++; $display("FAIL reboot got=%h/%b/%b exp=%h/1/0", imem_bus.imem_addr, imem_bus.imem_req, IF_ID_valid, RST_PC);
    end
    cyc(0, 3'd0, 32'h0, 1'b1);
    checks++;
    if (IF_ID_PC4 !== 32'h0000_3004 || IF_ID_valid !== 1'b1) begin
      errors++; $display("FAIL reboot_capture got=%h/%b exp=00003004/1", IF_ID_PC4, IF_ID_valid);
    end
  endtask

  task automatic test_random();
    bit          st, rdy;
    logic [2:0]  src;
    logic [31:0] jr;
    int unsigned r;
    do_reset();
    ovr_addr = 32'hFFFF_FFFF;
    cyc(0, 3'd0, 32'h0, 1'b1);
    for (int i = 0; i < 3000 && errors < 20; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      r   = $urandom_range(0, 15);
      src = (r < 8) ? 3'd0 : 3'(r - 8);
      jr  = $urandom & 32'hFFFF_FFFC;
      cyc(st, src, jr, rdy);
      checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL random_cycle_%0d got=%h exp=%h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_jr();
    test_wait_states();
    test_redirect_wait();
    test_reset_midwait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
